cpu_halt_bridge: RTL and testbench
==================================

Name: cpu_halt_bridge

Overview:
- Sits between the Maria core and the 6502 core (T65). Maria raises a DMA halt request; this block turns it into CPU clock enables.
- 6502C "Sally" timing: a halt takes effect only at a read-cycle boundary. Writes already in flight finish first.
- Drives the bus-released indication back to the DMA side.
- NMI from Maria's DLI logic is deferred while the CPU is halted, then stretched so the CPU samples it.
- Keeps a per-line count of halted CPU cycles for debug.

Parameters:
- MAX_WRITE_RUN, 3: maximum consecutive write cycles completed while a halt is pending before the halt is forced.
- NMI_STRETCH, 2: number of CPU cycles (cpu_ce strobes) that nmi_b_out is held low.
- CNT_W, 13: width of the halted-cycle counter.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset_b  in  1  asynchronous, active-low reset.
- pclk0_in  in  1  one-clk_sys strobe at CPU phase-0 edge.
- pclk1_in  in  1  one-clk_sys strobe at CPU phase-1 edge (end of CPU cycle).
- halt_b_in  in  1  Maria halt request, active low.
- ready_in  in  1  Maria READY; low stalls CPU read cycles.
- int_b_in  in  1  Maria NMI request, active low, edge-significant.
- cpu_rw  in  1  current CPU cycle direction: 1 = read, 0 = write.
- line_start  in  1  strobe that clears the counter (Maria lrc).
- cpu_ce  out  1  CPU clock enable, one clk_sys pulse.
- bus_released  out  1  CPU is off the bus; DMA may drive AB.
- nmi_b_out  out  1  NMI to CPU, active low.
- halted_cycles  out  CNT_W  CPU cycles spent halted since the last line_start.
- err_write_overrun  out  1  sticky; the halt was forced during a write.

Behaviour:
- Reset (asynchronous, reset_b low) sets:
  - state = RUN, write_run = 0, nmi_pending = 0, stretch count = 0.
  - cpu_ce = 0, bus_released = 0, nmi_b_out = 1, halted_cycles = 0, err_write_overrun = 0.
- Strobes: pclk0_in and pclk1_in are never high together. If they are, pclk1_in is processed and pclk0_in is ignored.
- cpu_ce is registered. It is high for exactly the clk_sys cycle after an accepted pclk1_in, i.e. one cycle of latency.
- State machine (all transitions occur on pclk1_in unless noted):
  - RUN:
    - halt_b_in high: issue cpu_ce, except when ready_in = 0 and cpu_rw = 1, which gives no ce (RDY stall).
    - halt_b_in low, cpu_rw = 1: go to HALTED with no ce.
    - halt_b_in low, cpu_rw = 0: issue ce, set write_run = 1, go to HALT_PEND.
  - HALT_PEND:
    - halt_b_in high: go to RUN with normal ce rules; clear write_run (cancelled halt).
    - cpu_rw = 1: go to HALTED, no ce.
    - cpu_rw = 0 and write_run < MAX_WRITE_RUN: issue ce, increment write_run.
    - cpu_rw = 0 and write_run == MAX_WRITE_RUN: go to HALTED, no ce, set err_write_overrun.
  - HALTED:
    - bus_released = 1, evaluated combinationally from state.
    - Each pclk1_in increments halted_cycles; the counter saturates at all-ones.
    - On pclk0_in with halt_b_in high: go to RESUME.
  - RESUME:
    - bus_released = 0.
    - On the next pclk1_in: go to RUN, issue ce, clear write_run.
    - If halt_b_in falls again before that pclk1_in: return to HALTED (no ce).
- ready_in has no effect in HALT_PEND, HALTED or RESUME beyond the rules above.
- NMI handling:
  - A falling edge on int_b_in (registered previous value) sets nmi_pending, in any state.
  - Stretch starts at the first issued cpu_ce after nmi_pending is set, so it is deferred while halted.
  - nmi_b_out is driven low at that ce and held low for NMI_STRETCH ce pulses; then it returns to 1 and nmi_pending clears.
  - A new edge during an active stretch is merged (ignored); there is no re-trigger.
- line_start:
  - Clears halted_cycles.
  - If it coincides with an increment, the clear wins and the result is 0.
- err_write_overrun clears only on reset.

Decomposition:
- Shared package maria_pkg:
  - typedef enum halt_state_t {RUN, HALT_PEND, HALTED, RESUME}.
  - Default constants for MAX_WRITE_RUN and NMI_STRETCH.
- One sub-module, nmi_stretcher: edge detect, pending latch, and stretch counter, gated by cpu_ce.

Test Plan:
- Halt on read: RUN, cpu_rw=1, drop halt_b_in, 5 pclk1 strobes.
  - Expect no cpu_ce, bus_released=1 after first pclk1, halted_cycles=5.
- Halt during write burst: cpu_rw=0 for 2 cycles then 1.
  - Expect 2 ce pulses, then HALTED, err_write_overrun=0.
- Overrun: cpu_rw held 0 with halt_b_in low.
  - Expect exactly 3 ce pulses, then HALTED, err_write_overrun=1.
- Resume: release halt_b_in while HALTED.
  - Expect bus_released=0 after next pclk0, first ce one clk_sys cycle after the following pclk1.
- Deferred NMI: int_b_in falls while HALTED.
  - Expect nmi_b_out stays 1 until resume, then low for exactly 2 ce pulses.
- Async reset mid-HALTED: pulse reset_b low.
  - Expect bus_released=0, halted_cycles=0, nmi_b_out=1 immediately, without waiting for clk_sys.

Source files
------------

// File: rtl/maria_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maria_pkg
// Description : Shared types and default constants for the Maria <-> 6502
//               halt bridge (halt state encoding, write-run and NMI stretch
//               defaults, halted-cycle counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package maria_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2,
        RESUME    = 2'd3
    } halt_state_t;

    localparam int unsigned DEF_MAX_WRITE_RUN = 3;
    localparam int unsigned DEF_NMI_STRETCH   = 2;
    localparam int unsigned DEF_CNT_W         = 13;

endpackage : maria_pkg
`default_nettype wire

// File: rtl/cpu_halt_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_halt_bridge_if
// Description : Handshake bundle between Maria/6502 timing and the halt
//               bridge.
//   pclk0_in / pclk1_in : CPU phase strobes (one clk_sys each)
//   halt_b_in           : Maria halt request, active low
//   ready_in            : Maria READY, low stalls CPU reads
//   int_b_in            : Maria NMI request, active low, edge significant
//   cpu_rw              : current CPU cycle direction, 1 = read
//   cpu_ce              : CPU clock enable pulse
//   bus_released        : CPU is off the bus
//   nmi_b_out           : stretched NMI to the CPU, active low
//   modport slave  : the bridge
//   modport master : the surrounding Maria/CPU environment
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_halt_bridge_if;
    logic pclk0_in;
    logic pclk1_in;
    logic halt_b_in;
    logic ready_in;
    logic int_b_in;
    logic cpu_rw;
    logic cpu_ce;
    logic bus_released;
    logic nmi_b_out;

    modport slave (
        input  pclk0_in, pclk1_in, halt_b_in, ready_in, int_b_in, cpu_rw,
        output cpu_ce, bus_released, nmi_b_out
    );

    modport master (
        output pclk0_in, pclk1_in, halt_b_in, ready_in, int_b_in, cpu_rw,
        input  cpu_ce, bus_released, nmi_b_out
    );
endinterface : cpu_halt_bridge_if
`default_nettype wire

// File: rtl/nmi_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : nmi_stretcher
// Description : Detects falling edges of the Maria NMI request, holds them
//               pending until the CPU is next clocked, then drives the NMI
//               low for NMI_STRETCH CPU clock enables.
//   clk_sys  : system clock
//   reset_b  : asynchronous active-low reset
//   i_int_b  : raw NMI request, active low
//   i_ce_set : high in the clk_sys cycle that launches a cpu_ce pulse
//   o_nmi_b  : stretched NMI, active low, registered
// Revision    : 1.0 - initial release
// ============================================================================
module nmi_stretcher #(
    parameter int unsigned NMI_STRETCH = 2
) (
    input  wire logic clk_sys,
    input  wire logic reset_b,
    input  wire logic i_int_b,
    input  wire logic i_ce_set,
    output logic      o_nmi_b
);
    localparam int unsigned   CW    = $clog2(NMI_STRETCH + 1);
    localparam logic [CW-1:0] C_MAX = CW'(NMI_STRETCH);

    logic          r_int_prev;
    logic          r_pend;
    logic [CW-1:0] r_cnt;
    logic          w_fall;

    assign w_fall = r_int_prev & ~i_int_b;

    // i_ce_set is the pre-register ce decision, so o_nmi_b changes on the
    // same edge that raises cpu_ce and the CPU sees it during that pulse.
    // r_cnt counts low pulses already issued; non-zero means a stretch is
    // active and new edges are merged into it.
    always_ff @(posedge clk_sys or negedge reset_b) begin
        if (!reset_b) begin
            r_int_prev <= 1'b1;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            o_nmi_b    <= 1'b1;
        end else begin
            r_int_prev <= i_int_b;
            if (w_fall && (r_cnt == '0))
                r_pend <= 1'b1;
            if (i_ce_set) begin
                if (r_cnt == C_MAX) begin
                    o_nmi_b <= 1'b1;
                    r_cnt   <= '0;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (r_pend) begin
                    o_nmi_b <= 1'b0;
                    r_cnt   <= CW'(1);
                    r_pend  <= 1'b0;
                end
            end
        end
    end
endmodule : nmi_stretcher
`default_nettype wire

// File: rtl/cpu_halt_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cpu_halt_bridge
// Description : Converts Maria DMA halt requests into 6502 clock enables,
//               honouring read-cycle-boundary halting, releases the bus to
//               DMA, defers/stretches NMI and counts halted CPU cycles.
//   clk_sys           : system clock
//   reset_b           : asynchronous active-low reset
//   line_start        : clears halted_cycles
//   bus               : handshake bundle (slave modport)
//   halted_cycles     : CPU cycles halted since the last line_start
//   err_write_overrun : sticky, halt was forced during a write
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_halt_bridge
    import maria_pkg::*;
#(
    parameter int unsigned MAX_WRITE_RUN = DEF_MAX_WRITE_RUN,
    parameter int unsigned NMI_STRETCH   = DEF_NMI_STRETCH,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  wire logic             clk_sys,
    input  wire logic             reset_b,
    input  wire logic             line_start,
    cpu_halt_bridge_if.slave      bus,
    output logic [CNT_W-1:0]      halted_cycles,
    output logic                  err_write_overrun
);
    localparam int unsigned     WR_W     = $clog2(MAX_WRITE_RUN + 1);
    localparam logic [WR_W-1:0] C_MAX_WR = WR_W'(MAX_WRITE_RUN);

    halt_state_t     r_state;
    logic [WR_W-1:0] r_write_run;
    logic            r_ce;
    logic            w_pclk0;
    logic            w_pclk1;
    logic            w_halt_req;
    logic            w_rdy_stall;
    logic            w_wr_full;
    logic            w_ce_set;
    logic            w_enter_halt;
    logic            w_count;
    logic            w_nmi_b;

    // pclk1 has priority when both strobes collide.
    assign w_pclk1     = bus.pclk1_in;
    assign w_pclk0     = bus.pclk0_in & ~bus.pclk1_in;
    assign w_halt_req  = ~bus.halt_b_in;
    assign w_rdy_stall = ~bus.ready_in & bus.cpu_rw;
    assign w_wr_full   = (r_write_run == C_MAX_WR);

    // End-of-CPU-cycle decision: issue a ce, or end the cycle halted.
    always_comb begin
        w_ce_set     = 1'b0;
        w_enter_halt = 1'b0;
        if (w_pclk1) begin
            case (r_state)
                RUN, HALT_PEND: begin
                    if (!w_halt_req)
                        w_ce_set = ~w_rdy_stall;
                    else if (bus.cpu_rw || (r_state == HALT_PEND && w_wr_full))
                        w_enter_halt = 1'b1;
                    else
                        w_ce_set = 1'b1;
                end
                RESUME: begin
                    if (w_halt_req) w_enter_halt = 1'b1;
                    else            w_ce_set     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The cycle that ends by entering HALTED is itself a halted CPU cycle.
    assign w_count = w_pclk1 & ((r_state == HALTED) | w_enter_halt);

    always_ff @(posedge clk_sys or negedge reset_b) begin
        if (!reset_b) begin
            r_state           <= RUN;
            r_write_run       <= '0;
            r_ce              <= 1'b0;
            halted_cycles     <= '0;
            err_write_overrun <= 1'b0;
        end else begin
            r_ce <= w_ce_set;
            case (r_state)
                RUN: begin
                    if (w_pclk1 && w_halt_req) begin
                        if (bus.cpu_rw) begin
                            r_state <= HALTED;
                        end else begin
                            r_state     <= HALT_PEND;
                            r_write_run <= WR_W'(1);
                        end
                    end
                end
                HALT_PEND: begin
                    if (w_pclk1) begin
                        if (!w_halt_req) begin
                            r_state     <= RUN;
                            r_write_run <= '0;
                        end else if (bus.cpu_rw) begin
                            r_state <= HALTED;
                        end else if (!w_wr_full) begin
                            r_write_run <= r_write_run + 1'b1;
                        end else begin
                            r_state           <= HALTED;
                            err_write_overrun <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (w_pclk0 && !w_halt_req)
                        r_state <= RESUME;
                end
                RESUME: begin
                    // A fresh halt before the resuming pclk1 cancels it.
                    if (w_halt_req) begin
                        r_state <= HALTED;
                    end else if (w_pclk1) begin
                        r_state     <= RUN;
                        r_write_run <= '0;
                    end
                end
                default: r_state <= RUN;
            endcase
            if (line_start)
                halted_cycles <= '0;
            else if (w_count && (halted_cycles != '1))
                halted_cycles <= halted_cycles + 1'b1;
        end
    end

    nmi_stretcher #(
        .NMI_STRETCH (NMI_STRETCH)
    ) u_nmi_stretcher (
        .clk_sys  (clk_sys),
        .reset_b  (reset_b),
        .i_int_b  (bus.int_b_in),
        .i_ce_set (w_ce_set),
        .o_nmi_b  (w_nmi_b)
    );

    assign bus.cpu_ce       = r_ce;
    assign bus.bus_released = (r_state == HALTED);
    assign bus.nmi_b_out    = w_nmi_b;
endmodule : cpu_halt_bridge
`default_nettype wire

// File: tb/tb_cpu_halt_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_halt_bridge
// Description : Self-checking bench for cpu_halt_bridge: directed scenarios
//               plus randomized CPU cycles against a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_halt_bridge;
    localparam int MAXW = 3;
    localparam int NST  = 2;

    logic        clk_sys = 1'b0;
    logic        reset_b;
    logic        line_start;
    logic [12:0] halted_cycles;
    logic        err_write_overrun;

    int n_checks = 0;
    int n_errors = 0;

    // observations of the last CPU cycle
    logic o_ce, o_extra, o_bus_mid, o_nmi;

    cpu_halt_bridge_if u_if ();

    cpu_halt_bridge #(
        .MAX_WRITE_RUN (MAXW),
        .NMI_STRETCH   (NST),
        .CNT_W         (13)
    ) dut (
        .clk_sys           (clk_sys),
        .reset_b           (reset_b),
        .line_start        (line_start),
        .bus               (u_if.slave),
        .halted_cycles     (halted_cycles),
        .err_write_overrun (err_write_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    // One CPU cycle: pclk0 strobe, two idle clocks, pclk1 strobe, one idle.
    // halt_b is h0 around pclk0 and h1 from mid-cycle through pclk1.
    task automatic cpu_cycle(input logic h0, input logic h1, input logic rw,
                             input logic rdy, input logic ls, input logic ib);
        u_if.int_b_in  = ib;
        u_if.halt_b_in = h0;
        u_if.cpu_rw    = rw;
        u_if.ready_in  = rdy;
        o_extra        = 1'b0;
        u_if.pclk0_in  = 1'b1;
        tick;
        u_if.pclk0_in  = 1'b0;
        o_extra        = o_extra | u_if.cpu_ce;
        tick;
        o_bus_mid      = u_if.bus_released;
        o_extra        = o_extra | u_if.cpu_ce;
        u_if.halt_b_in = h1;
        tick;
        o_extra        = o_extra | u_if.cpu_ce;
        u_if.pclk1_in  = 1'b1;
        line_start     = ls;
        tick;
        u_if.pclk1_in  = 1'b0;
        line_start     = 1'b0;
        o_ce           = u_if.cpu_ce;
        o_nmi          = u_if.nmi_b_out;
        tick;
        o_extra        = o_extra | u_if.cpu_ce;
    endtask

    task automatic do_reset;
        u_if.pclk0_in = 1'b0; u_if.pclk1_in = 1'b0; u_if.halt_b_in = 1'b1;
        u_if.ready_in = 1'b1; u_if.int_b_in = 1'b1; u_if.cpu_rw = 1'b1;
        line_start = 1'b0;
        reset_b = 1'b0;
        tick; tick;
        reset_b = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        u_if.pclk0_in = 1'b0; u_if.pclk1_in = 1'b0; u_if.halt_b_in = 1'b1;
        u_if.ready_in = 1'b1; u_if.int_b_in = 1'b1; u_if.cpu_rw = 1'b1;
        line_start = 1'b0;
        reset_b = 1'b0;
        tick; tick;
        n_checks++; if (u_if.cpu_ce !== 1'b0) begin n_errors++; $display("FAIL reset_ce got=%b want=0", u_if.cpu_ce); end
        n_checks++; if (u_if.bus_released !== 1'b0) begin n_errors++; $display("FAIL reset_bus got=%b want=0", u_if.bus_released); end
        n_checks++; if (u_if.nmi_b_out !== 1'b1) begin n_errors++; $display("FAIL reset_nmi got=%b want=1", u_if.nmi_b_out); end
        n_checks++; if (halted_cycles !== 13'd0) begin n_errors++; $display("FAIL reset_cnt got=%0d want=0", halted_cycles); end
        n_checks++; if (err_write_overrun !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b want=0", err_write_overrun); end
        reset_b = 1'b1;
        tick;
    endtask

    task automatic test_halt_on_read;
        int ces = 0;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            cpu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            ces += int'(o_ce);
            if (i == 0) begin
                n_checks++; if (u_if.bus_released !== 1'b1) begin n_errors++; $display("FAIL read_halt_bus got=%b want=1", u_if.bus_released); end
            end
        end
        n_checks++; if (ces != 0) begin n_errors++; $display("FAIL read_halt_ce got=%0d want=0", ces); end
        n_checks++; if (halted_cycles !== 13'd5) begin n_errors++; $display("FAIL read_halt_cnt got=%0d want=5", halted_cycles); end
    endtask

    task automatic test_write_burst;
        int ces = 0;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            cpu_cycle(1'b0, 1'b0, (i == 2), 1'b1, 1'b0, 1'b1);
            ces += int'(o_ce);
        end
        n_checks++; if (ces != 2) begin n_errors++; $display("FAIL burst_ce got=%0d want=2", ces); end
        n_checks++; if (u_if.bus_released !== 1'b1) begin n_errors++; $display("FAIL burst_bus got=%b want=1", u_if.bus_released); end
        n_checks++; if (err_write_overrun !== 1'b0) begin n_errors++; $display("FAIL burst_err got=%b want=0", err_write_overrun); end
    endtask

    task automatic test_overrun;
        int ces = 0;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            cpu_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            ces += int'(o_ce);
        end
        n_checks++; if (ces != MAXW) begin n_errors++; $display("FAIL overrun_ce got=%0d want=%0d", ces, MAXW); end
        n_checks++; if (u_if.bus_released !== 1'b1) begin n_errors++; $display("FAIL overrun_bus got=%b want=1", u_if.bus_released); end
        n_checks++; if (err_write_overrun !== 1'b1) begin n_errors++; $display("FAIL overrun_err got=%b want=1", err_write_overrun); end
        n_checks++; if (halted_cycles !== 13'd2) begin n_errors++; $display("FAIL overrun_cnt got=%0d want=2", halted_cycles); end
    endtask

    // continues from the HALTED state left by test_overrun
    task automatic test_resume;
        cpu_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (o_bus_mid !== 1'b0) begin n_errors++; $display("FAIL resume_bus_mid got=%b want=0", o_bus_mid); end
        n_checks++; if (o_ce !== 1'b1) begin n_errors++; $display("FAIL resume_ce got=%b want=1", o_ce); end
        n_checks++; if (o_extra !== 1'b0) begin n_errors++; $display("FAIL resume_ce_timing got=%b want=0", o_extra); end
        n_checks++; if (err_write_overrun !== 1'b1) begin n_errors++; $display("FAIL resume_err_sticky got=%b want=1", err_write_overrun); end
    endtask

    task automatic test_deferred_nmi;
        int lows = 0;
        int early = 0;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            cpu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, (i < 2));
            early += int'(!u_if.nmi_b_out);
        end
        n_checks++; if (early != 0) begin n_errors++; $display("FAIL nmi_deferred got_low=%0d want=0", early); end
        for (int i = 0; i < 4; i++) begin
            cpu_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                n_checks++; if (o_nmi !== 1'b0) begin n_errors++; $display("FAIL nmi_first_ce got=%b want=0", o_nmi); end
            end
            if (o_ce && !o_nmi) lows++;
        end
        n_checks++; if (lows != NST) begin n_errors++; $display("FAIL nmi_stretch got=%0d want=%0d", lows, NST); end
        n_checks++; if (u_if.nmi_b_out !== 1'b1) begin n_errors++; $display("FAIL nmi_release got=%b want=1", u_if.nmi_b_out); end
    endtask

    task automatic test_line_start;
        do_reset;
        for (int i = 0; i < 3; i++) cpu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (halted_cycles !== 13'd3) begin n_errors++; $display("FAIL ls_pre got=%0d want=3", halted_cycles); end
        cpu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (halted_cycles !== 13'd0) begin n_errors++; $display("FAIL ls_clear_wins got=%0d want=0", halted_cycles); end
        cpu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (halted_cycles !== 13'd1) begin n_errors++; $display("FAIL ls_post got=%0d want=1", halted_cycles); end
    endtask

    task automatic test_async_reset;
        do_reset;
        for (int i = 0; i < 3; i++) cpu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (u_if.bus_released !== 1'b1) begin n_errors++; $display("FAIL areset_pre_bus got=%b want=1", u_if.bus_released); end
        @(posedge clk_sys);
        #2 reset_b = 1'b0;
        #1;
        n_checks++; if (u_if.bus_released !== 1'b0) begin n_errors++; $display("FAIL areset_bus got=%b want=0", u_if.bus_released); end
        n_checks++; if (halted_cycles !== 13'd0) begin n_errors++; $display("FAIL areset_cnt got=%0d want=0", halted_cycles); end
        n_checks++; if (u_if.nmi_b_out !== 1'b1) begin n_errors++; $display("FAIL areset_nmi got=%b want=1", u_if.nmi_b_out); end
        tick;
        reset_b = 1'b1;
        tick;
    endtask

    task automatic test_random;
        bit m_off = 0, m_pendh = 0, m_err = 0;
        int m_wr = 0, m_cnt = 0;
        bit m_ib_prev = 1, m_npend = 0, m_str = 0;
        int m_done = 0;
        logic h0 = 1'b1, h1, rw, rdy, ls, ib;
        bit exp_ce, exp_mid, exp_n, counted;
        do_reset;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) h0 = ~h0;
            h1  = ($urandom_range(0, 7) == 0) ? ~h0 : h0;
            rw  = ($urandom_range(0, 1) == 0);
            rdy = ($urandom_range(0, 4) != 0);
            ls  = ($urandom_range(0, 15) == 0);
            ib  = ($urandom_range(0, 5) != 0);

            // NMI edges are merged into an active stretch
            if (m_ib_prev && !ib && !m_str) m_npend = 1;
            m_ib_prev = ib;

            exp_mid = m_off && !h0;
            exp_ce  = 0;
            counted = 0;
            if (m_off) begin
                if (h0 && h1) begin exp_ce = 1; m_off = 0; m_pendh = 0; end
                else counted = 1;
            end else if (!h1) begin
                if (rw || (m_pendh && m_wr == MAXW)) begin
                    if (!rw) m_err = 1;
                    m_off = 1; m_pendh = 0; counted = 1;
                end else begin
                    exp_ce = 1;
                    m_wr = m_pendh ? m_wr + 1 : 1;
                    m_pendh = 1;
                end
            end else begin
                exp_ce = !(rw && !rdy);
                m_pendh = 0;
            end
            if (counted && m_cnt < 8191) m_cnt++;
            if (ls) m_cnt = 0;

            exp_n = 1;
            if (exp_ce) begin
                if (m_str && m_done == NST) m_str = 0;
                else if (m_str) begin exp_n = 0; m_done++; end
                else if (m_npend) begin exp_n = 0; m_str = 1; m_done = 1; m_npend = 0; end
            end

            cpu_cycle(h0, h1, rw, rdy, ls, ib);

            n_checks++; if (o_ce !== exp_ce) begin n_errors++; $display("FAIL rnd_ce cyc=%0d got=%b want=%b", c, o_ce, exp_ce); end
            n_checks++; if (o_extra !== 1'b0) begin n_errors++; $display("FAIL rnd_ce_extra cyc=%0d got=%b want=0", c, o_extra); end
            n_checks++; if (o_bus_mid !== exp_mid) begin n_errors++; $display("FAIL rnd_bus_mid cyc=%0d got=%b want=%b", c, o_bus_mid, exp_mid); end
            n_checks++; if (u_if.bus_released !== m_off) begin n_errors++; $display("FAIL rnd_bus cyc=%0d got=%b want=%b", c, u_if.bus_released, m_off); end
            n_checks++; if (int'(halted_cycles) != m_cnt) begin n_errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", c, halted_cycles, m_cnt); end
            n_checks++; if (err_write_overrun !== m_err) begin n_errors++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", c, err_write_overrun, m_err); end
            if (exp_ce) begin
                n_checks++; if (o_nmi !== exp_n) begin n_errors++; $display("FAIL rnd_nmi cyc=%0d got=%b want=%b", c, o_nmi, exp_n); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_halt_on_read;
        test_write_burst;
        test_overrun;
        test_resume;
        test_deferred_nmi;
        test_line_start;
        test_async_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule : tb_cpu_halt_bridge
`default_nettype wire
